// File: rtl/des_sbox_engine.sv
// Time-multiplexed DES substitution stage: LANES of the eight S-boxes per cycle,
// 48-bit expanded word in, 32-bit substituted word out.
module des_sbox_engine #(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int STEPS = 8 / LANES;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    // One 256-bit row-major table per box: entry {row,col} sits at nibble 63-{row,col}.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
        logic [255:0] shifted;
        shifted = SBOX[box] >> {~{b[5], b[0], b[4:1]}, 2'b00};
        return shifted[3:0];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   step;
    logic [7:0][5:0] hold;
    logic [7:0][3:0] result;

    logic [2:0] lane_box [LANES];
    logic [3:0] lane_nib [LANES];

    // Box k lives in group 7-k of both the holding and result registers (S1 is the MSBs).
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_box[j] = 3'(int'(step) * LANES + j);
        assign lane_nib[j] = sbox_lookup(lane_box[j], hold[3'd7 - lane_box[j]]);
    end

    // Handshake: a word moves on a port at a rising edge where valid and ready are both
    // high; out_valid stays high with out_data stable until out_ready takes it.
    assign in_ready  = !clear && ((state == IDLE) || ((state == DONE) && out_ready));
    assign out_data  = result;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            step      <= '0;
            hold      <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            step      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold  <= in_data;
                        step  <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < LANES; j++) begin
                        result[3'd7 - lane_box[j]] <= lane_nib[j];
                    end
                    if (step == SW'(STEPS - 1)) begin
                        step      <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        step <= step + SW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            hold  <= in_data;
                            step  <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/des_sbox_engine.md
# des_sbox_engine

Parametrised, time-multiplexed DES substitution stage: accepts one 48-bit expanded-and-key-mixed word, runs it through the eight standard DES S-boxes LANES boxes per clock, and returns the 32-bit substituted word. Sits between the round key-mix XOR and the P-permutation in the round datapath. Inputs and outputs use a valid/ready handshake, so the round controller can stall on either side. LANES trades area (number of physical S-box lookups) against latency.

## Interface
- LANES, 2, S-boxes evaluated per cycle; legal values 1, 2, 4, 8 (other values are an elaboration error)
- clk  in  1  rising-edge clock
- n_rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort: drop any word in flight, return to IDLE
- in_valid  in  1  in_data is valid
- in_ready  out  1  engine can accept a word this cycle
- in_data  in  48  expanded word; bits [47:42] feed S1, ..., bits [5:0] feed S8
- out_valid  out  1  out_data holds a completed result
- out_ready  in  1  consumer takes out_data this cycle
- out_data  out  32  substituted word; S1 result in [31:28], ..., S8 result in [3:0]
- busy  out  1  high in BUSY or DONE

## Operation
- Per-box lookup on a 6-bit group b[5:0]: row = {b5,b0}, column = b[4:1]; table contents are the eight standard DES S-boxes (FIPS 46-3). Table functions are pure combinational, instantiated LANES times.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid: capture in_data into a 48-bit holding register, clear step counter, go BUSY.
- BUSY: each cycle, lanes j=0..LANES-1 evaluate box index step*LANES+j and write their 4-bit results into the matching nibble of a 32-bit result register; step increments. After step reaches 8/LANES-1 and completes, go DONE. For LANES=8, BUSY lasts exactly one cycle.
- DONE: out_valid=1, out_data = result register (held stable until taken). On out_ready: if in_valid also high (in_ready=1 here), capture the new word and go BUSY; else go IDLE.
- in_ready = (state==IDLE) or (state==DONE and out_ready). in_ready is never high in BUSY.
- Step counter width: clog2(8/LANES), minimum 1 bit; wraps to 0 on entry to BUSY.
- clear: highest priority over every transition; next state IDLE, out_valid drops next cycle, a simultaneous in_valid is not accepted (in_ready forced 0 while clear=1). Result register contents after clear are don't-care but out_valid must not rise.
- No partial results are ever visible: out_valid only with all eight nibbles written for the current word.

## Timing
- Reset (n_rst low, async): state IDLE, in_ready=1 once n_rst released, out_valid=0, busy=0, out_data=0, holding/result registers 0, step=0.
- Reset asserted mid-BUSY or in DONE: word discarded immediately; no out_valid afterward.
- Latency: accept on edge k, out_valid high after edge k+8/LANES (LANES=2: 4 cycles; LANES=1: 8; LANES=8: 1).
- Throughput with out_ready held high: one word per 8/LANES+1 cycles... except the DONE→BUSY handoff makes it one word per 8/LANES cycles plus the DONE cycle, i.e. 8/LANES+1 cycles/word.
- out_data and out_valid are registered outputs; in_ready is combinational from state, out_ready and clear.
- Back-pressure: out_ready low in DONE holds out_valid and out_data indefinitely; in_ready stays 0.

## Test plan
- Reset: drive n_rst low mid-BUSY -> out_valid=0, busy=0, out_data=0 immediately; after release in_ready=1.
- in_data=0x000000000000, out_ready=1 -> out_data=0xEFA72C4D exactly 8/LANES cycles after accept; repeat for LANES=1,2,4,8.
- in_data=0xFFFFFFFFFFFF -> out_data=0xD9CE3DCB; in_data=0x6117BA866527 -> out_data=0x5C82B597.
- Back-pressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; then out_ready=1 with in_valid=1 -> new word accepted same cycle, next result follows 8/LANES cycles later.
- clear asserted during BUSY (and separately in DONE with in_valid=1) -> IDLE next cycle, no out_valid, new word not accepted.
- Random stream of 1000 words with random in_valid/out_ready stalls, scoreboarded against a reference DES S-box model -> in-order, no drops, no duplicates.
